traffic_conflict_monitor: RTL

Safety stage directly downstream of the traffic light controller. Consumes its encoded direction lights and left-arrow requests, checks every cycle for conflicting or illegal aspects and bad sequencing, and drives one-hot lamp outputs. On any violation it latches a fault code and forces all-way flashing red until an operator clear is accepted.

---
 rtl/traffic_conflict_monitor_if.sv | 24 ++
 rtl/traffic_conflict_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor_if.sv
// Signal bundle between the light controller and the conflict monitor.
interface traffic_conflict_monitor_if;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       ns_left;
  logic       ew_left;
  logic       fault_clear;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       ns_left_lamp;
  logic       ew_left_lamp;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output ns_light, ew_light, ns_left, ew_left, fault_clear,
    input  ns_lamp, ew_lamp, ns_left_lamp, ew_left_lamp, fault, fault_code
  );

  modport slave (
    input  ns_light, ew_light, ns_left, ew_left, fault_clear,
    output ns_lamp, ew_lamp, ns_left_lamp, ew_left_lamp, fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the light controller and the lamp drivers; forces flashing red on any violation.
// Optional arrow checking (fault code 3) is enabled by defining TRAFFIC_MON_LEFT_CHECK_EN.
//
// state   | meaning
// MONITOR | inputs legal so far; lamps decode controller aspects one cycle late
// FAULT   | violation latched; all-way flashing red until an accepted clear
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 4
) (
  input logic clk,
  input logic reset,
  traffic_conflict_monitor_if.slave bus
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    prev_ns, prev_ew;
  logic [YW-1:0] ycnt_ns, ycnt_ew, ycnt_ns_nxt, ycnt_ew_nxt;
  logic [FW-1:0] flash_cnt, flash_cnt_nxt;
  logic          phase, phase_nxt;
  logic [2:0]    ns_lamp_q, ew_lamp_q, ns_lamp_nxt, ew_lamp_nxt;
  logic          ns_left_q, ew_left_q, ns_left_nxt, ew_left_nxt;
  logic [2:0]    code_q, code_nxt;
  logic [2:0]    viol;
  logic          arrow_bad;
  logic          clear_ok;

  function automatic logic [2:0] decode(input logic [1:0] a);
    case (a)
      GREEN:   decode = 3'b001;
      YELLOW:  decode = 3'b010;
      default: decode = LAMP_RED;
    endcase
  endfunction

  function automatic logic [YW-1:0] ycnt_next(input logic [1:0] a, input logic [YW-1:0] c);
    if (a != YELLOW)                ycnt_next = '0;
    else if (c == YW'(MIN_YELLOW))  ycnt_next = c;
    else                            ycnt_next = c + 1'b1;
  endfunction

  assign ycnt_ns_nxt = ycnt_next(bus.ns_light, ycnt_ns);
  assign ycnt_ew_nxt = ycnt_next(bus.ew_light, ycnt_ew);

`ifdef TRAFFIC_MON_LEFT_CHECK_EN
  assign arrow_bad = (bus.ns_left && (bus.ns_light != GREEN || bus.ew_light != RED)) ||
                     (bus.ew_left && (bus.ew_light != GREEN || bus.ns_light != RED));
`else
  assign arrow_bad = 1'b0;
`endif

  assign clear_ok = bus.fault_clear && bus.ns_light == RED && bus.ew_light == RED &&
                    !bus.ns_left && !bus.ew_left;

  // Lowest code wins when several checks fire together.
  always_comb begin
    viol = 3'd0;
    if (bus.ns_light == BAD || bus.ew_light == BAD)
      viol = 3'd1;
    else if (bus.ns_light != RED && bus.ew_light != RED)
      viol = 3'd2;
    else if (arrow_bad)
      viol = 3'd3;
    else if ((prev_ns == GREEN && bus.ns_light == RED) ||
             (prev_ew == GREEN && bus.ew_light == RED))
      viol = 3'd4;
    else if ((prev_ns == YELLOW && bus.ns_light == RED && ycnt_ns < YW'(MIN_YELLOW)) ||
             (prev_ew == YELLOW && bus.ew_light == RED && ycnt_ew < YW'(MIN_YELLOW)))
      viol = 3'd5;
  end

  always_comb begin
    state_nxt     = state;
    flash_cnt_nxt = flash_cnt;
    phase_nxt     = phase;
    code_nxt      = code_q;
    ns_lamp_nxt   = ns_lamp_q;
    ew_lamp_nxt   = ew_lamp_q;
    ns_left_nxt   = 1'b0;
    ew_left_nxt   = 1'b0;
    case (state)
      MONITOR: begin
        if (viol != 3'd0) begin
          state_nxt     = FAULT;
          code_nxt      = viol;
          flash_cnt_nxt = '0;
          phase_nxt     = 1'b1;
          ns_lamp_nxt   = LAMP_RED;
          ew_lamp_nxt   = LAMP_RED;
        end else begin
          code_nxt    = 3'd0;
          ns_lamp_nxt = decode(bus.ns_light);
          ew_lamp_nxt = decode(bus.ew_light);
          ns_left_nxt = bus.ns_left;
          ew_left_nxt = bus.ew_left;
        end
      end
      FAULT: begin
        if (clear_ok) begin
          state_nxt     = MONITOR;
          code_nxt      = 3'd0;
          flash_cnt_nxt = '0;
          phase_nxt     = 1'b1;
          ns_lamp_nxt   = LAMP_RED;
          ew_lamp_nxt   = LAMP_RED;
        end else begin
          if (flash_cnt == FW'(FLASH_HALF - 1)) begin
            flash_cnt_nxt = '0;
            phase_nxt     = ~phase;
          end else begin
            flash_cnt_nxt = flash_cnt + 1'b1;
          end
          ns_lamp_nxt = phase_nxt ? LAMP_RED : LAMP_OFF;
          ew_lamp_nxt = phase_nxt ? LAMP_RED : LAMP_OFF;
        end
      end
      default: state_nxt = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MONITOR;
      prev_ns   <= RED;
      prev_ew   <= RED;
      ycnt_ns   <= '0;
      ycnt_ew   <= '0;
      flash_cnt <= '0;
      phase     <= 1'b1;
      code_q    <= 3'd0;
      ns_lamp_q <= LAMP_RED;
      ew_lamp_q <= LAMP_RED;
      ns_left_q <= 1'b0;
      ew_left_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_ns   <= bus.ns_light;
      prev_ew   <= bus.ew_light;
      ycnt_ns   <= ycnt_ns_nxt;
      ycnt_ew   <= ycnt_ew_nxt;
      flash_cnt <= flash_cnt_nxt;
      phase     <= phase_nxt;
      code_q    <= code_nxt;
      ns_lamp_q <= ns_lamp_nxt;
      ew_lamp_q <= ew_lamp_nxt;
      ns_left_q <= ns_left_nxt;
      ew_left_q <= ew_left_nxt;
    end
  end

  assign bus.ns_lamp      = ns_lamp_q;
  assign bus.ew_lamp      = ew_lamp_q;
  assign bus.ns_left_lamp = ns_left_q;
  assign bus.ew_left_lamp = ew_left_q;
  assign bus.fault        = (state == FAULT);
  assign bus.fault_code   = code_q;

endmodule
